// File: rtl/fir_out_requant_fifo.sv
// FIR output stage: round half-up by SHIFT, saturate to OUT_W, buffer in a FWFT FIFO.
// Latency: sample enters FIFO two edges after in_valid.
// Backpressure: none upstream; samples arriving on a full FIFO with no pop are dropped and flagged.

module sync_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 8,
  parameter int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_vld,
  input  logic [W-1:0]     push_dat,
  output logic             pop_vld,
  input  logic             pop_rdy,
  output logic [W-1:0]     pop_dat,
  output logic [LVL_W-1:0] level,
  output logic             full,
  output logic             drop
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [W-1:0]  hold_q;
  logic          do_push;
  logic          do_pop;

  assign pop_vld = (level != '0);
  assign full    = (level == LVL_W'(DEPTH));
  assign do_pop  = pop_vld & pop_rdy;
  // A pop in the same cycle frees a slot, so a full FIFO still accepts the push.
  assign do_push = push_vld & (~full | do_pop);
  assign drop    = push_vld & full & ~do_pop;
  assign pop_dat = pop_vld ? mem[rd_ptr] : hold_q;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      hold_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
        hold_q <= mem[rd_ptr];
      end
      case ({do_push, do_pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end
endmodule

module fir_out_requant_fifo #(
  parameter int IN_W  = 32,
  parameter int OUT_W = 16,
  parameter int SHIFT = 15,
  parameter int DEPTH = 8,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [IN_W-1:0]          y_in,
  input  logic                     in_valid,
  output logic [OUT_W-1:0]         out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     overflow,
  output logic [CNT_W-1:0]         sat_count,
  input  logic                     clr_flags
);
  // Half-LSB rounding constant; collapses to zero when SHIFT is 0.
  localparam logic signed [IN_W:0] RND  = ({{IN_W{1'b0}}, 1'b1} << SHIFT) >> 1;
  localparam logic signed [IN_W:0] SMAX = {{(IN_W+2-OUT_W){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [IN_W:0] SMIN = {{(IN_W+2-OUT_W){1'b1}}, {(OUT_W-1){1'b0}}};
  localparam logic [OUT_W-1:0]     OMAX = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0]     OMIN = {1'b1, {(OUT_W-1){1'b0}}};

  logic signed [IN_W:0] y_ext;
  logic signed [IN_W:0] rnd_sum;
  logic                 s1_vld;
  logic signed [IN_W:0] s1_r;
  logic                 sat_hi;
  logic                 sat_lo;
  logic                 sat_evt;
  logic [OUT_W-1:0]     s2_nxt;
  logic                 s2_vld;
  logic [OUT_W-1:0]     s2_dat;
  logic                 drop;

  always_comb begin
    y_ext   = $signed({y_in[IN_W-1], y_in});
    rnd_sum = y_ext + RND;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_vld <= 1'b0;
      s1_r   <= '0;
    end else begin
      s1_vld <= in_valid;
      if (in_valid) s1_r <= rnd_sum >>> SHIFT;
    end
  end

  always_comb begin
    sat_hi  = (s1_r > SMAX);
    sat_lo  = (s1_r < SMIN);
    sat_evt = s1_vld & (sat_hi | sat_lo);
    s2_nxt  = s1_r[OUT_W-1:0];
    if (sat_hi) s2_nxt = OMAX;
    else if (sat_lo) s2_nxt = OMIN;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s2_vld <= 1'b0;
      s2_dat <= '0;
    end else begin
      s2_vld <= s1_vld;
      if (s1_vld) s2_dat <= s2_nxt;
    end
  end

  sync_fifo #(
    .W     (OUT_W),
    .DEPTH (DEPTH),
    .LVL_W ($clog2(DEPTH) + 1)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push_vld (s2_vld),
    .push_dat (s2_dat),
    .pop_vld  (out_valid),
    .pop_rdy  (out_ready),
    .pop_dat  (out_data),
    .level    (level),
    .full     (full),
    .drop     (drop)
  );

  // A new event in the clearing cycle takes priority over the clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow  <= 1'b0;
      sat_count <= '0;
    end else begin
      if (drop) overflow <= 1'b1;
      else if (clr_flags) overflow <= 1'b0;

      if (clr_flags) sat_count <= sat_evt ? CNT_W'(1) : '0;
      else if (sat_evt && !(&sat_count)) sat_count <= sat_count + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_fir_out_requant_fifo.sv
// Directed bench for fir_out_requant_fifo: table of single-sample vectors plus
// hand-written sequences for fill/overflow, push+pop on full, and mid-run reset.
module tb_fir_out_requant_fifo;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] y_in;
  logic        in_valid;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  level;
  logic        full;
  logic        overflow;
  logic [15:0] sat_count;
  logic        clr_flags;

  int n_chk  = 0;
  int n_fail = 0;
  int exp_sat = 0;

  typedef struct {
    logic [31:0] y;
    logic [15:0] dat;
    logic        sat;
  } vec_t;
  vec_t vecs[11];

  always #5 clk = ~clk;

  fir_out_requant_fifo dut (
    .clk       (clk),
    .rst       (rst),
    .y_in      (y_in),
    .in_valid  (in_valid),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .level     (level),
    .full      (full),
    .overflow  (overflow),
    .sat_count (sat_count),
    .clr_flags (clr_flags)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  initial begin
    vecs[0]  = '{32'h0001_2345, 16'h0002, 1'b0};
    vecs[1]  = '{32'h0000_4000, 16'h0001, 1'b0};
    vecs[2]  = '{32'h0000_3FFF, 16'h0000, 1'b0};
    vecs[3]  = '{32'hFFFF_C000, 16'h0000, 1'b0};
    vecs[4]  = '{32'hFFFF_BFFF, 16'hFFFF, 1'b0};
    vecs[5]  = '{32'h7FFF_FFFF, 16'h7FFF, 1'b1};
    vecs[6]  = '{32'h8000_0000, 16'h8000, 1'b1};
    vecs[7]  = '{32'h3FFF_BFFF, 16'h7FFF, 1'b0};
    vecs[8]  = '{32'h3FFF_C000, 16'h7FFF, 1'b1};
    vecs[9]  = '{32'hC000_0000, 16'h8000, 1'b0};
    vecs[10] = '{32'hBFFF_BFFF, 16'h8000, 1'b1};

    rst = 1'b1; y_in = '0; in_valid = 1'b0; out_ready = 1'b0; clr_flags = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data",  32'(out_data),  32'd0);
    chk("rst_level",     32'(level),     32'd0);
    chk("rst_full",      32'(full),      32'd0);
    chk("rst_overflow",  32'(overflow),  32'd0);
    chk("rst_sat_count", 32'(sat_count), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Single-sample vectors: exact two-edge latency, value, then pop and hold.
    for (int i = 0; i < 11; i++) begin
      y_in = vecs[i].y; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      chk($sformatf("v%0d_early_valid", i), 32'(out_valid), 32'd0);
      @(negedge clk);
      if (vecs[i].sat) exp_sat++;
      chk($sformatf("v%0d_valid", i), 32'(out_valid), 32'd1);
      chk($sformatf("v%0d_data", i),  32'(out_data),  32'(vecs[i].dat));
      chk($sformatf("v%0d_level", i), 32'(level),     32'd1);
      chk($sformatf("v%0d_sat", i),   32'(sat_count), 32'(exp_sat));
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk($sformatf("v%0d_pop_level", i), 32'(level),    32'd0);
      chk($sformatf("v%0d_hold_data", i), 32'(out_data), 32'(vecs[i].dat));
    end

    clr_flags = 1'b1;
    @(negedge clk);
    clr_flags = 1'b0;
    chk("clr_sat_count", 32'(sat_count), 32'd0);

    // Ten samples into an 8-deep FIFO with no consumer.
    for (int v = 1; v <= 10; v++) begin
      y_in = 32'(v) << 15; in_valid = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("fill_level",    32'(level),    32'd8);
    chk("fill_full",     32'(full),     32'd1);
    chk("fill_overflow", 32'(overflow), 32'd1);
    chk("fill_head",     32'(out_data), 32'd1);
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      chk($sformatf("drain_%0d", i), 32'(out_data), 32'(i));
      @(negedge clk);
    end
    out_ready = 1'b0;
    chk("drain_level", 32'(level),     32'd0);
    chk("drain_valid", 32'(out_valid), 32'd0);
    chk("drain_hold",  32'(out_data),  32'd8);

    // Clear coinciding with a saturation event: event wins.
    y_in = 32'h7FFF_FFFF; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; clr_flags = 1'b1;
    @(negedge clk);
    clr_flags = 1'b0;
    chk("clr_evt_sat_count", 32'(sat_count), 32'd1);
    chk("clr_evt_overflow",  32'(overflow),  32'd0);
    @(negedge clk);
    chk("clr_evt_data", 32'(out_data), 32'h7FFF);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;

    // Full FIFO, push and pop land on the same edge.
    for (int v = 11; v <= 18; v++) begin
      y_in = 32'(v) << 15; in_valid = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("pp_pre_level", 32'(level), 32'd8);
    y_in = 32'(19) << 15; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("pp_level",    32'(level),    32'd8);
    chk("pp_full",     32'(full),     32'd1);
    chk("pp_overflow", 32'(overflow), 32'd0);
    chk("pp_head",     32'(out_data), 32'd12);
    out_ready = 1'b1;
    for (int i = 12; i <= 19; i++) begin
      chk($sformatf("pp_drain_%0d", i), 32'(out_data), 32'(i));
      @(negedge clk);
    end
    out_ready = 1'b0;
    chk("pp_drain_level", 32'(level), 32'd0);

    // Reset with 5 buffered and 2 in flight.
    for (int v = 1; v <= 7; v++) begin
      y_in = 32'(v) << 15; in_valid = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("mid_level", 32'(level), 32'd5);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_level", 32'(level),     32'd0);
    chk("mid_rst_data",  32'(out_data),  32'd0);
    chk("mid_rst_sat",   32'(sat_count), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk($sformatf("post_rst_valid_%0d", i), 32'(out_valid), 32'd0);
    end
    y_in = 32'h0001_2345; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("post_rst_new_valid", 32'(out_valid), 32'd1);
    chk("post_rst_new_data",  32'(out_data),  32'd2);
    chk("post_rst_new_level", 32'(level),     32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
